recv_m5m7: RTL and testbench



---
 rtl/m5m7_pkg.sv | 41 ++++
 rtl/m5m7_halfbit_sampler.sv | 62 ++++++
 rtl/recv_m5m7.sv | 162 ++++++++++++++++
 tb/tb_recv_m5m7.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/m5m7_pkg.sv
// Shared M5/M7 line definitions: frame head, Manchester pair encoding, word sizes
// and the receiver state encoding. The M5/M7 transmitter uses the same package.
package m5m7_pkg;

  localparam int WORD_W      = 16;
  localparam int HB_PER_WORD = 2 * WORD_W;
  localparam int HB_CNT_W    = $clog2(HB_PER_WORD);
  localparam int HEAD_LEN    = 22;

  // Tail of the frame head as seen on each rail, first half-bit in the MSB
  localparam logic [HEAD_LEN-1:0] HEAD_BO = 22'b1010101010101010000111;
  localparam logic [HEAD_LEN-1:0] HEAD_BZ = ~HEAD_BO;

  // Pair values on bz, first half-bit in the MSB
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_HUNT  = 4'b0010,
    ST_DATA  = 4'b0100,
    ST_ERROR = 4'b1000
  } rx_state_t;

  // Returns {all_pairs_valid, word}; pair [2i+1:2i] carries word bit i
  function automatic logic [WORD_W:0] decode_word(input logic [HB_PER_WORD-1:0] hb);
    logic [WORD_W-1:0] w;
    logic              ok;
    w  = '0;
    ok = 1'b1;
    for (int i = 0; i < WORD_W; i++) begin
      case (hb[2*i+1 -: 2])
        PAIR_ONE:  w[i] = 1'b1;
        PAIR_ZERO: w[i] = 1'b0;
        default:   ok   = 1'b0;
      endcase
    end
    return {ok, w};
  endfunction

endpackage

// File: rtl/m5m7_halfbit_sampler.sv
// Synchronizes the dual-rail line, keeps half-bit phase locked to bz edges and
// strobes one sample per half-bit; also flags a line with no bz edge for too long.
module m5m7_halfbit_sampler #(
  parameter int SPH = 4
) (
  input  logic clock_57,
  input  logic reset,
  input  logic m5_boi,
  input  logic m5_bzi,
  output logic hb_valid,
  output logic hb_bo,
  output logic hb_bz,
  output logic stalled
);

  localparam int CNT_W     = $clog2(SPH);
  localparam int STALL_MAX = 2 * SPH + 1;
  localparam int STALL_W   = $clog2(STALL_MAX + 1);

  logic [1:0]         bo_sync;
  logic [1:0]         bz_sync;
  logic               bz_prev;
  logic               bz_edge;
  logic [CNT_W-1:0]   phase;
  logic [CNT_W-1:0]   phase_next;
  logic [STALL_W-1:0] stall_cnt;

  assign bz_edge = bz_sync[1] ^ bz_prev;
  assign stalled = (stall_cnt == STALL_W'(STALL_MAX));

  // A bz edge marks a half-bit boundary; between edges the phase free-runs
  always_comb begin
    phase_next = phase + 1'b1;
    if (bz_edge || phase == CNT_W'(SPH - 1)) phase_next = '0;
  end

  always_ff @(posedge clock_57) begin
    if (reset) begin
      bo_sync   <= 2'b11;
      bz_sync   <= 2'b11;
      bz_prev   <= 1'b1;
      phase     <= '0;
      stall_cnt <= '0;
      hb_valid  <= 1'b0;
      hb_bo     <= 1'b1;
      hb_bz     <= 1'b1;
    end else begin
      bo_sync  <= {bo_sync[0], m5_boi};
      bz_sync  <= {bz_sync[0], m5_bzi};
      bz_prev  <= bz_sync[1];
      phase    <= phase_next;
      hb_valid <= (phase_next == CNT_W'(SPH / 2));
      if (phase_next == CNT_W'(SPH / 2)) begin
        hb_bo <= bo_sync[1];
        hb_bz <= bz_sync[1];
      end
      if (bz_edge) stall_cnt <= '0;
      else if (!stalled) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/recv_m5m7.sv
// M5/M7 Manchester receiver: idle qualification, head hunt, word decode and the
// DSP holding register. Define RECV_M5M7_RAILCHK_EN to also enforce bo == ~bz.
module recv_m5m7
  import m5m7_pkg::*;
#(
  parameter int SPH     = 4,
  parameter int IDLE_HB = 10
) (
  input  logic              clock_57,
  input  logic              reset,
  input  logic              m5_boi,
  input  logic              m5_bzi,
  input  logic              rden_rx,
  input  logic              err_clr,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              rx_overrun,
  output logic              rx_error,
  output logic              frame_active,
  output rx_state_t         fsm_state
);

  localparam int IDLE_W = $clog2(IDLE_HB + 1);

  logic                   hb_valid, hb_bo, hb_bz, stalled;
  rx_state_t              state;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [HEAD_LEN-1:0]    head_sr, head_next;
  logic [HB_PER_WORD-1:0] data_sr, data_next;
  logic [HB_CNT_W-1:0]    hb_cnt;
  logic                   first_hi;
  logic [WORD_W:0]        dec;
  logic                   both_hi, last_hb, end_pair;
  logic                   rail_err_head, rail_err_data, align_err;
  logic                   err_evt, word_load;

  m5m7_halfbit_sampler #(.SPH(SPH)) u_sampler (
    .clock_57 (clock_57),
    .reset    (reset),
    .m5_boi   (m5_boi),
    .m5_bzi   (m5_bzi),
    .hb_valid (hb_valid),
    .hb_bo    (hb_bo),
    .hb_bz    (hb_bz),
    .stalled  (stalled)
  );

  assign fsm_state = state;
  assign both_hi   = hb_bo & hb_bz;
  assign head_next = {head_sr[HEAD_LEN-2:0], hb_bo};
  assign data_next = {data_sr[HB_PER_WORD-2:0], hb_bz};
  assign dec       = decode_word(data_next);
  assign last_hb   = (hb_cnt == HB_CNT_W'(HB_PER_WORD - 1));
  // Both rails high across the first pair of a word closes the frame
  assign end_pair  = (hb_cnt == HB_CNT_W'(1)) && first_hi && both_hi;
  assign align_err = stalled && (hb_cnt >= HB_CNT_W'(2));

  always_comb begin
    rail_err_head = 1'b0;
    rail_err_data = 1'b0;
`ifdef RECV_M5M7_RAILCHK_EN
    rail_err_head = (hb_bo == hb_bz) && !both_hi;
    rail_err_data = ((hb_bo == hb_bz) && !(hb_cnt == '0 && both_hi) && !end_pair)
                 || ((hb_cnt == HB_CNT_W'(1)) && first_hi && !end_pair);
`endif
  end

  always_comb begin
    err_evt = 1'b0;
    if (state == ST_DATA)
      err_evt = align_err || (hb_valid && (rail_err_data || (last_hb && !dec[WORD_W])));
    else if (state == ST_HUNT)
      err_evt = hb_valid && rail_err_head;
  end

  assign word_load = (state == ST_DATA) && hb_valid && last_hb && dec[WORD_W] && !err_evt;

  always_ff @(posedge clock_57) begin
    if (reset) begin
      state        <= ST_IDLE;
      idle_cnt     <= '0;
      head_sr      <= '1;
      data_sr      <= '0;
      hb_cnt       <= '0;
      first_hi     <= 1'b0;
      rx_data      <= '0;
      rx_ready     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_error     <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      if (err_clr) begin
        rx_error   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (err_evt) rx_error <= 1'b1;

      // rx_ready means rx_data holds an unread word; a rden_rx strobe consumes it.
      // A word landing on a full register is an overrun unless consumed that cycle.
      if (word_load) begin
        rx_data  <= dec[WORD_W-1:0];
        rx_ready <= 1'b1;
        if (rx_ready && !rden_rx) rx_overrun <= 1'b1;
      end else if (rden_rx) begin
        rx_ready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (hb_valid) begin
            if (!both_hi) begin
              idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(IDLE_HB - 1)) begin
              idle_cnt <= '0;
              head_sr  <= '1;
              state    <= ST_HUNT;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end
        ST_HUNT: begin
          if (hb_valid) begin
            if (rail_err_head) begin
              state <= ST_ERROR;
            end else begin
              head_sr <= head_next;
              if (head_next == HEAD_BO) begin
                state        <= ST_DATA;
                frame_active <= 1'b1;
                hb_cnt       <= '0;
                first_hi     <= 1'b0;
              end
            end
          end
        end
        ST_DATA: begin
          if (err_evt) begin
            state <= ST_ERROR;
          end else if (hb_valid) begin
            if (end_pair) begin
              state        <= ST_IDLE;
              frame_active <= 1'b0;
              idle_cnt     <= '0;
            end else begin
              data_sr <= data_next;
              hb_cnt  <= hb_cnt + 1'b1;
              if (hb_cnt == '0) first_hi <= both_hi;
            end
          end
        end
        ST_ERROR: begin
          frame_active <= 1'b0;
          idle_cnt     <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recv_m5m7.sv
// Bench for recv_m5m7: builds whole line frames half-bit by half-bit and compares
// the host-side outputs with a frame-level model of the receiver behaviour.
module tb_recv_m5m7;

  localparam int SPH = 4;

  logic        clock_57 = 1'b0;
  logic        reset;
  logic        m5_boi, m5_bzi, rden_rx, err_clr;
  logic [15:0] rx_data;
  logic        rx_ready, rx_overrun, rx_error, frame_active;
  logic [3:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  logic [21:0] head_ref = 22'b1010101010101010000111;
  logic [3:0]  st_idle_ref = 4'b0001;

  // Model of the host-visible state
  logic [15:0] m_data;
  bit          m_ready, m_overrun, m_error;

  recv_m5m7 #(.SPH(SPH), .IDLE_HB(10)) dut (
    .clock_57     (clock_57),
    .reset        (reset),
    .m5_boi       (m5_boi),
    .m5_bzi       (m5_bzi),
    .rden_rx      (rden_rx),
    .err_clr      (err_clr),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_error     (rx_error),
    .frame_active (frame_active),
    .fsm_state    (fsm_state)
  );

  always #5 clock_57 = ~clock_57;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},    32'(rx_data),      32'(m_data));
    check({tag, ".ready"},   32'(rx_ready),     32'(m_ready));
    check({tag, ".overrun"}, 32'(rx_overrun),   32'(m_overrun));
    check({tag, ".error"},   32'(rx_error),     32'(m_error));
    check({tag, ".fa_end"},  32'(frame_active), 32'd0);
  endtask

  task automatic pulse_read();
    rden_rx = 1'b1;
    @(negedge clock_57);
    rden_rx = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clock_57);
    err_clr = 1'b0;
    m_error   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // Expected effect of one whole frame on the host-visible state
  task automatic model_frame(input int nw, input logic [15:0] w0, w1, w2,
                             input int bad_pair, input int rail_hb,
                             input int head_flip, input bit rd_last, input int rst_hb);
    bit          corrupt;
    logic [15:0] w;
    corrupt = (bad_pair >= 0);
`ifdef RECV_M5M7_RAILCHK_EN
    if (rail_hb >= 0) corrupt = 1'b1;
`endif
    if (rst_hb >= 0) begin
      m_data = '0; m_ready = 0; m_overrun = 0; m_error = 0;
    end else if (head_flip >= 0) begin
      if (rd_last) m_ready = 0;
    end else if (corrupt) begin
      m_error = 1;
      if (rd_last) m_ready = 0;
    end else begin
      for (int k = 0; k < nw; k++) begin
        w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
        if (m_ready && !(rd_last && k == nw - 1)) m_overrun = 1;
        m_data  = w;
        m_ready = 1;
      end
    end
  endtask

  // Drives idle, head, nw words, end pair and trailing idle onto the line
  task automatic send_frame(input int nw, input logic [15:0] w0, w1, w2,
                            input int bad_pair, input int rail_hb,
                            input int head_flip, input bit rd_last, input int rst_hb,
                            output logic fa_mid);
    logic [1:0]  q[$];
    logic [21:0] head;
    logic [15:0] w;
    logic [1:0]  bz2;
    int          data_start, rd_idx;
    head = head_ref;
    if (head_flip >= 0) head[head_flip] = ~head[head_flip];
    repeat (12) q.push_back(2'b11);
    for (int i = 21; i >= 0; i--) q.push_back({head[i], ~head[i]});
    data_start = q.size();
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : (k == 1) ? w1 : w2;
      for (int b = 15; b >= 0; b--) begin
        bz2 = w[b] ? 2'b10 : 2'b01;
        q.push_back({~bz2[1], bz2[1]});
        q.push_back({~bz2[0], bz2[0]});
      end
    end
    if (bad_pair >= 0) begin
      q[data_start + 2*bad_pair]     = 2'b11;
      q[data_start + 2*bad_pair + 1] = 2'b11;
    end
    if (rail_hb >= 0) q[data_start + rail_hb] = {q[data_start + rail_hb][0], q[data_start + rail_hb][0]};
    rd_idx = q.size();
    repeat (4) q.push_back(2'b11);
    fa_mid = 1'b0;
    for (int n = 0; n < q.size(); n++) begin
      m5_boi = q[n][1];
      m5_bzi = q[n][0];
      for (int j = 0; j < SPH; j++) begin
        rden_rx = rd_last && (n == rd_idx) && (j == 1);
        reset   = (rst_hb >= 0) && (n == data_start + rst_hb) && (j < 3);
        @(negedge clock_57);
        if (n == data_start + 1 && j == SPH - 1) fa_mid = frame_active;
        if (rst_hb >= 0 && n == data_start + rst_hb && j == 2) begin
          check("rst.data",    32'(rx_data),      32'd0);
          check("rst.ready",   32'(rx_ready),     32'd0);
          check("rst.overrun", 32'(rx_overrun),   32'd0);
          check("rst.error",   32'(rx_error),     32'd0);
          check("rst.fa",      32'(frame_active), 32'd0);
          check("rst.state",   32'(fsm_state),    32'(st_idle_ref));
        end
      end
    end
    rden_rx = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int nw, input logic [15:0] w0, w1, w2,
                           input int bad_pair, input int rail_hb,
                           input int head_flip, input bit rd_last, input int rst_hb);
    logic fa_mid;
    send_frame(nw, w0, w1, w2, bad_pair, rail_hb, head_flip, rd_last, rst_hb, fa_mid);
    model_frame(nw, w0, w1, w2, bad_pair, rail_hb, head_flip, rd_last, rst_hb);
    check({tag, ".fa_mid"}, 32'(fa_mid), (head_flip >= 0) ? 32'd0 : 32'd1);
    check_model(tag);
  endtask

  initial begin
    reset = 1'b1; m5_boi = 1'b1; m5_bzi = 1'b1; rden_rx = 1'b0; err_clr = 1'b0;
    m_data = '0; m_ready = 0; m_overrun = 0; m_error = 0;
    repeat (3) @(negedge clock_57);
    check("por.state", 32'(fsm_state), 32'(st_idle_ref));
    check_model("por");
    reset = 1'b0;
    repeat (5) @(negedge clock_57);

    // Single word, then a read clears ready but holds the data
    run_frame("a5c3", 1, 16'hA5C3, 16'h0, 16'h0, -1, -1, -1, 1'b0, -1);
    check("a5c3.const", 32'(rx_data), 32'h0000A5C3);
    pulse_read();
    check("a5c3.rd_ready", 32'(rx_ready), 32'd0);
    check("a5c3.rd_data",  32'(rx_data),  32'h0000A5C3);

    // Back-to-back words without a read overrun
    run_frame("ovr", 2, 16'h1234, 16'hFFFF, 16'h0, -1, -1, -1, 1'b0, -1);
    check("ovr.const", 32'(rx_overrun), 32'd1);
    pulse_clr();
    check("ovr.clr", 32'(rx_overrun), 32'd0);
    pulse_read();

    // Read coincident with the second word keeps ready and avoids overrun
    run_frame("coin", 2, 16'h1234, 16'hFFFF, 16'h0, -1, -1, -1, 1'b1, -1);
    check("coin.ready", 32'(rx_ready),   32'd1);
    check("coin.ovr",   32'(rx_overrun), 32'd0);
    pulse_read();

    // Invalid pair 5 raises error, err_clr clears it, next clean frame decodes
    run_frame("pair5", 1, 16'h00F0, 16'h0, 16'h0, 5, -1, -1, 1'b0, -1);
    check("pair5.err", 32'(rx_error), 32'd1);
    pulse_clr();
    check("pair5.clr", 32'(rx_error), 32'd0);
    run_frame("after", 1, 16'h0001, 16'h0, 16'h0, -1, -1, -1, 1'b0, -1);
    pulse_read();

    // Corrupted head: no frame, nothing captured
    run_frame("hflip", 1, 16'h5555, 16'h0, 16'h0, -1, -1, 3, 1'b0, -1);

    // bo equal to bz on one data half-bit
    run_frame("rail", 1, 16'hBEEF, 16'h0, 16'h0, -1, 6, -1, 1'b0, -1);
    pulse_clr();
    pulse_read();

    // Reset mid-way through the second word of a frame
    run_frame("rstmid", 2, 16'h1111, 16'h2222, 16'h0, -1, -1, -1, 1'b0, 42);

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      int   nw, bp;
      bit   rdl;
      nw  = $urandom_range(1, 3);
      bp  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : -1;
      rdl = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) pulse_read();
      if ($urandom_range(0, 1) == 1) pulse_clr();
      run_frame($sformatf("rnd%0d", r), nw, 16'($urandom), 16'($urandom), 16'($urandom),
                bp, -1, -1, rdl, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
